// File: rtl/riscv_wb_arbiter.sv
// Register-file write arbiter: the single-cycle ALU result (port A) has priority.
// Long-latency results (port B) are buffered in a small FIFO and drain into the
// regfile write port when A is idle. Pending writes are exposed for RAW-hazard probes.
module riscv_wb_arbiter #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 4,
  localparam int unsigned PtrWidth = $clog2(FifoDepth),
  localparam int unsigned CntWidth = PtrWidth + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 a_valid_i,
  input  logic [AddrWidth-1:0] a_addr_i,
  input  logic [DataWidth-1:0] a_data_i,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [AddrWidth-1:0] b_addr_i,
  input  logic [DataWidth-1:0] b_data_i,
  output logic                 wr_en_o,
  output logic [AddrWidth-1:0] wr_addr_o,
  output logic [DataWidth-1:0] wr_data_o,
  output logic [CntWidth-1:0]  b_count_o,
  input  logic [AddrWidth-1:0] chk_addr_a_i,
  input  logic [AddrWidth-1:0] chk_addr_b_i,
  output logic                 chk_hit_a_o,
  output logic                 chk_hit_b_o
);

  logic [AddrWidth-1:0] fifo_addr_q [FifoDepth];
  logic [DataWidth-1:0] fifo_data_q [FifoDepth];

  logic [PtrWidth-1:0]  wptr_q, wptr_d;
  logic [PtrWidth-1:0]  rptr_q, rptr_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic                 rdy_en_q;

  logic                 wr_en_q, wr_en_d;
  logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
  logic [DataWidth-1:0] wr_data_q, wr_data_d;

  logic                 a_sel;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic [PtrWidth-1:0]  offs;
  logic                 hit_a_fifo, hit_b_fifo;

  // Handshake and arbitration decisions; writes to x0 never enter the pipeline.
  assign a_sel     = a_valid_i & (a_addr_i != '0);
  assign full      = (count_q == CntWidth'(FifoDepth));
  // rdy_en_q keeps ready low until the first edge after reset release.
  assign b_ready_o = rdy_en_q & ~full;
  assign push      = b_valid_i & b_ready_o & (b_addr_i != '0);
  assign pop       = ~a_sel & (count_q != '0);

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign b_count_o = count_q;

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PtrWidth'(1);
    if (pop)  rptr_d = rptr_q + PtrWidth'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // Output stage selection: A first, then FIFO head, else idle with held address/data.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (a_sel) begin
      wr_en_d   = 1'b1;
      wr_addr_d = a_addr_i;
      wr_data_d = a_data_i;
    end else if (pop) begin
      wr_en_d   = 1'b1;
      wr_addr_d = fifo_addr_q[rptr_q];
      wr_data_d = fifo_data_q[rptr_q];
    end
  end

  // Hazard probes: match against live FIFO entries and the write in flight.
  always_comb begin
    hit_a_fifo = 1'b0;
    hit_b_fifo = 1'b0;
    offs       = '0;
    for (int i = 0; i < FifoDepth; i++) begin
      // Entry i is live if its distance from the read pointer is below occupancy.
      offs = PtrWidth'(i) - rptr_q;
      if ({1'b0, offs} < count_q) begin
        if (fifo_addr_q[i] == chk_addr_a_i) hit_a_fifo = 1'b1;
        if (fifo_addr_q[i] == chk_addr_b_i) hit_b_fifo = 1'b1;
      end
    end
    chk_hit_a_o = (chk_addr_a_i != '0) &
                  (hit_a_fifo | (wr_en_q & (wr_addr_q == chk_addr_a_i)));
    chk_hit_b_o = (chk_addr_b_i != '0) &
                  (hit_b_fifo | (wr_en_q & (wr_addr_q == chk_addr_b_i)));
  end

  // Control state: pointers, occupancy, ready enable and registered write port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rdy_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rdy_en_q  <= 1'b1;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // FIFO storage; contents are only meaningful under the occupancy count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= b_addr_i;
      fifo_data_q[wptr_q] <= b_data_i;
    end
  end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter: vector table for the A path plus
// hand-written multi-cycle sequences for buffering, backpressure, hazards and reset.
module tb_riscv_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  b_count;
  logic [4:0]  chk_addr_a;
  logic [4:0]  chk_addr_b;
  logic        chk_hit_a;
  logic        chk_hit_b;

  int n_cmp;
  int n_err;

  riscv_wb_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .a_valid_i    (a_valid),
    .a_addr_i     (a_addr),
    .a_data_i     (a_data),
    .b_valid_i    (b_valid),
    .b_ready_o    (b_ready),
    .b_addr_i     (b_addr),
    .b_data_i     (b_data),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .b_count_o    (b_count),
    .chk_addr_a_i (chk_addr_a),
    .chk_addr_b_i (chk_addr_b),
    .chk_hit_a_o  (chk_hit_a),
    .chk_hit_b_o  (chk_hit_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic [4:0]  chk;
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string name, input logic en, input logic [4:0] addr,
                          input logic [31:0] data);
    check({name, ".wr_en"}, 32'(wr_en), 32'(en));
    check({name, ".wr_addr"}, 32'(wr_addr), 32'(addr));
    check({name, ".wr_data"}, wr_data, data);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    a_valid    = 1'b0;
    a_addr     = '0;
    a_data     = '0;
    b_valid    = 1'b0;
    b_addr     = '0;
    b_data     = '0;
    chk_addr_a = '0;
    chk_addr_b = '0;

    //                a_v  a_addr a_data         chk    en   addr   data           hit
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
    vecs[1] = '{1'b0, 5'd5,  32'h0,        5'd5,  1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 5'd0,  32'h1234,     5'd0,  1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{1'b1, 5'd1,  32'h0,        5'd0,  1'b1, 5'd1,  32'h0,        1'b0};
    vecs[5] = '{1'b0, 5'd7,  32'h99,       5'd1,  1'b0, 5'd1,  32'h0,        1'b0};

    // Reset state
    #12;
    check_wr("rst", 1'b0, 5'd0, 32'h0);
    check("rst.b_count", 32'(b_count), 32'd0);
    check("rst.b_ready", 32'(b_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rel.b_ready_low", 32'(b_ready), 32'd0);
    tick();
    check("rel.b_ready_high", 32'(b_ready), 32'd1);

    // A path table
    for (int i = 0; i < 6; i++) begin
      a_valid    = vecs[i].a_valid;
      a_addr     = vecs[i].a_addr;
      a_data     = vecs[i].a_data;
      chk_addr_a = vecs[i].chk;
      chk_addr_b = vecs[i].chk;
      tick();
      check_wr($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_addr, vecs[i].exp_data);
      check($sformatf("vec%0d.hit_a", i), 32'(chk_hit_a), 32'(vecs[i].exp_hit));
      check($sformatf("vec%0d.hit_b", i), 32'(chk_hit_b), 32'(vecs[i].exp_hit));
    end
    a_valid    = 1'b0;
    chk_addr_a = '0;
    chk_addr_b = '0;

    // B to x0: handshake completes, nothing buffered or written
    b_valid = 1'b1;
    b_addr  = 5'd0;
    b_data  = 32'h55;
    #1;
    check("x0.b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    check("x0.b_count", 32'(b_count), 32'd0);
    check("x0.wr_en", 32'(wr_en), 32'd0);
    check("x0.hit_a", 32'(chk_hit_a), 32'd0);
    tick();
    check("x0.wr_en2", 32'(wr_en), 32'd0);

    // Collision: A wins, B follows next cycle
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h22;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    check_wr("col.k1", 1'b1, 5'd3, 32'h11);
    check("col.cnt1", 32'(b_count), 32'd1);
    tick();
    check_wr("col.k2", 1'b1, 5'd4, 32'h22);
    check("col.cnt0", 32'(b_count), 32'd0);
    tick();
    check("col.idle", 32'(wr_en), 32'd0);

    // Full FIFO with A holding the port; pointers wrap on the fifth push
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
    b_valid = 1'b1;
    for (int r = 8; r < 12; r++) begin
      b_addr = 5'(r);
      b_data = 32'(r) << 8;
      #1;
      check($sformatf("full.ready%0d", r), 32'(b_ready), 32'd1);
      tick();
    end
    b_addr = 5'd12;
    b_data = 32'hC00;
    check("full.cnt4", 32'(b_count), 32'd4);
    check("full.ready0", 32'(b_ready), 32'd0);
    tick();
    tick();
    check("full.cnt_hold", 32'(b_count), 32'd4);
    check("full.a_out", 32'(wr_addr), 32'd1);
    chk_addr_a = 5'd11;
    chk_addr_b = 5'd12;
    #1;
    check("full.hit11", 32'(chk_hit_a), 32'd1);
    check("full.hit12", 32'(chk_hit_b), 32'd0);
    a_valid = 1'b0;
    tick();
    check_wr("full.w8", 1'b1, 5'd8, 32'h800);
    check("full.cnt3a", 32'(b_count), 32'd3);
    check("full.ready_back", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    check_wr("full.w9", 1'b1, 5'd9, 32'h900);
    check("full.cnt3b", 32'(b_count), 32'd3);
    tick();
    check_wr("full.w10", 1'b1, 5'd10, 32'hA00);
    check("full.cnt2", 32'(b_count), 32'd2);
    tick();
    check_wr("full.w11", 1'b1, 5'd11, 32'hB00);
    tick();
    check_wr("full.w12", 1'b1, 5'd12, 32'hC00);
    check("full.cnt0", 32'(b_count), 32'd0);
    tick();
    check("full.idle", 32'(wr_en), 32'd0);

    // Hazard: buffered r7, then in-flight r7, then clear
    chk_addr_a = 5'd7;
    chk_addr_b = 5'd6;
    a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h2;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77;
    tick();
    b_valid = 1'b0;
    check("haz.buf", 32'(chk_hit_a), 32'd1);
    check("haz.other", 32'(chk_hit_b), 32'd0);
    tick();
    check("haz.buf2", 32'(chk_hit_a), 32'd1);
    a_valid = 1'b0;
    tick();
    check_wr("haz.w7", 1'b1, 5'd7, 32'h77);
    check("haz.inflight", 32'(chk_hit_a), 32'd1);
    tick();
    check("haz.clear", 32'(chk_hit_a), 32'd0);
    chk_addr_a = '0;
    chk_addr_b = '0;

    // Reset in the middle of draining
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
    b_valid = 1'b1;
    for (int r = 8; r < 11; r++) begin
      b_addr = 5'(r);
      b_data = 32'(r) << 8;
      tick();
    end
    b_valid = 1'b0;
    a_valid = 1'b0;
    check("mrst.cnt3", 32'(b_count), 32'd3);
    tick();
    check_wr("mrst.w8", 1'b1, 5'd8, 32'h800);
    rst = 1'b1;
    #1;
    check_wr("mrst.async", 1'b0, 5'd0, 32'h0);
    check("mrst.cnt", 32'(b_count), 32'd0);
    check("mrst.ready", 32'(b_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mrst.ready_low", 32'(b_ready), 32'd0);
    tick();
    check("mrst.ready_high", 32'(b_ready), 32'd1);
    check("mrst.no_stale1", 32'(wr_en), 32'd0);
    tick();
    check("mrst.no_stale2", 32'(wr_en), 32'd0);
    check("mrst.cnt_end", 32'(b_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
